// File: rtl/ram_dp_mem.sv
// Dual-port RAM with one write port and one registered read port. After reset it
// zero-fills every word, one per cycle, before the ports accept traffic.
//
// state | meaning
// INIT  | zero-filling mem[init_cnt]; both ports held off, requests ignored
// RUN   | normal traffic; write-first bypass on same-address collision
module ram_dp_mem #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_enb,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready,
   input  logic                  rd_enb,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  init_busy
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {INIT, RUN} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
   logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic                    rd_valid_q, rd_valid_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    wr_acc, rd_acc;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_waddr;
   logic [DATA_WIDTH-1:0]   mem_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT;
         init_cnt_q <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Counter stops at the last address so it can never start a second pass.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      unique case (state_q)
         INIT: begin
            if (init_cnt_q == LAST_ADDR) begin
               state_d = RUN;
            end else begin
               init_cnt_d = init_cnt_q + ONE_ADDR;
            end
         end
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   always_comb begin
      init_busy = (state_q == INIT);
      wr_ready  = (state_q == RUN);
      rd_ready  = (state_q == RUN);
   end

   assign wr_acc = wr_enb && wr_ready;
   assign rd_acc = rd_enb && rd_ready;

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      if (state_q == INIT) begin
         mem_we    = 1'b1;
         mem_waddr = init_cnt_q;
         mem_wdata = '0;
      end else if (wr_acc) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Same-address write in the read cycle wins over the stored word.
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (rd_acc) begin
         rd_valid_d = 1'b1;
         if (wr_acc && (wr_addr == rd_addr)) begin
            rd_data_d = wr_data;
         end else begin
            rd_data_d = mem_q[rd_addr];
         end
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_dp_mem.sv
// Directed testbench for ram_dp_mem: init timing, write/read, collisions,
// streaming at the address boundaries and mid-run reset.
module tb_ram_dp_mem;

   localparam int DW    = 64;
   localparam int AW    = 12;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_enb;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          rd_enb;
   logic [AW-1:0] rd_addr;
   logic          rd_ready;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          init_busy;

   int n_chk  = 0;
   int n_pass = 0;

   ram_dp_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_enb    (wr_enb),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .rd_enb    (rd_enb),
      .rd_addr   (rd_addr),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .init_busy (init_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Drive one cycle's requests at a falling edge; return at the next falling edge.
   task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic re, input logic [AW-1:0] ra);
      wr_enb  = we;
      wr_addr = wa;
      wr_data = wd;
      rd_enb  = re;
      rd_addr = ra;
      @(negedge clk);
   endtask

   // Called at the falling edge where rst_n was just released.
   task automatic wait_init(input string tag);
      int cnt     = 0;
      int vld_bad = 0;
      while (init_busy && cnt < 5000) begin
         cnt++;
         if (rd_valid || wr_ready || rd_ready) vld_bad++;
         @(negedge clk);
      end
      wr_enb = 1'b0;
      rd_enb = 1'b0;
      chk({tag, "_busy_cycles"}, DW'(cnt), DW'(DEPTH));
      chk({tag, "_no_valid_or_ready"}, DW'(vld_bad), '0);
      chk({tag, "_wr_ready"}, DW'(wr_ready), 1);
      chk({tag, "_rd_ready"}, DW'(rd_ready), 1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bad_data;
      int bad_vld;
      logic [DW-1:0] exp_d;

      rst_n   = 1'b0;
      wr_enb  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_enb  = 1'b0;
      rd_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_data",   rd_data, '0);
      chk("rst_rd_valid",  DW'(rd_valid), 0);
      chk("rst_init_busy", DW'(init_busy), 1);
      chk("rst_wr_ready",  DW'(wr_ready), 0);
      chk("rst_rd_ready",  DW'(rd_ready), 0);

      // Requests held active throughout INIT must be ignored.
      rst_n   = 1'b1;
      wr_enb  = 1'b1;
      wr_addr = 12'h007;
      wr_data = 64'hAA;
      rd_enb  = 1'b1;
      rd_addr = 12'h007;
      wait_init("init1");

      bad_data = 0;
      bad_vld  = 0;
      for (int a = 0; a < DEPTH; a++) begin
         cycle(1'b0, '0, '0, 1'b1, AW'(a));
         if (rd_data !== '0) bad_data++;
         if (rd_valid !== 1'b1) bad_vld++;
      end
      chk("zero_fill_data_errors", DW'(bad_data), '0);
      chk("zero_fill_valid_errors", DW'(bad_vld), '0);
      cycle(1'b0, '0, '0, 1'b1, 12'h007);
      chk("init_ignored_wr_addr7", rd_data, '0);
      cycle(1'b0, '0, '0, 1'b0, '0);
      chk("idle_valid_low", DW'(rd_valid), 0);

      cycle(1'b1, 12'h005, 64'hDEAD_BEEF_0000_0001, 1'b0, '0);
      chk("wr_no_valid", DW'(rd_valid), 0);
      cycle(1'b0, '0, '0, 1'b1, 12'h005);
      chk("wr_rd_valid", DW'(rd_valid), 1);
      chk("wr_rd_data", rd_data, 64'hDEAD_BEEF_0000_0001);
      cycle(1'b0, '0, '0, 1'b0, '0);
      chk("wr_rd_valid_pulse", DW'(rd_valid), 0);
      chk("wr_rd_data_hold", rd_data, 64'hDEAD_BEEF_0000_0001);

      cycle(1'b1, 12'hFFF, 64'h1234, 1'b1, 12'hFFF);
      chk("coll_same_valid", DW'(rd_valid), 1);
      chk("coll_same_data", rd_data, 64'h1234);
      cycle(1'b1, 12'h011, 64'hBBBB, 1'b0, '0);
      cycle(1'b1, 12'h010, 64'h77, 1'b1, 12'h011);
      chk("coll_diff_old_data", rd_data, 64'hBBBB);
      cycle(1'b0, '0, '0, 1'b1, 12'h010);
      chk("coll_diff_wr_landed", rd_data, 64'h77);
      cycle(1'b0, '0, '0, 1'b1, 12'hFFF);
      chk("coll_same_wr_landed", rd_data, 64'h1234);

      cycle(1'b1, 12'h000, 64'hA0A0_0000_0000_A0A0, 1'b0, '0);
      cycle(1'b1, 12'hFFF, 64'h5F5F_FFFF_0000_5F5F, 1'b0, '0);
      bad_data = 0;
      bad_vld  = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, '0, '0, 1'b1, (i % 2 == 0) ? 12'h000 : 12'hFFF);
         exp_d = (i % 2 == 0) ? 64'hA0A0_0000_0000_A0A0 : 64'h5F5F_FFFF_0000_5F5F;
         if (rd_data !== exp_d) bad_data++;
         if (rd_valid !== 1'b1) bad_vld++;
      end
      chk("stream_data_errors", DW'(bad_data), '0);
      chk("stream_valid_errors", DW'(bad_vld), '0);
      cycle(1'b0, '0, '0, 1'b0, '0);
      chk("stream_end_valid", DW'(rd_valid), 0);
      chk("stream_end_hold", rd_data, 64'h5F5F_FFFF_0000_5F5F);

      cycle(1'b1, 12'h100, 64'h55, 1'b0, '0);
      cycle(1'b0, '0, '0, 1'b1, 12'h100);
      chk("pre_rst_valid", DW'(rd_valid), 1);
      chk("pre_rst_data", rd_data, 64'h55);
      rd_enb  = 1'b1;
      rd_addr = 12'h100;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_rd_valid",  DW'(rd_valid), 0);
      chk("midrst_rd_data",   rd_data, '0);
      chk("midrst_init_busy", DW'(init_busy), 1);
      chk("midrst_wr_ready",  DW'(wr_ready), 0);
      @(negedge clk);
      rst_n  = 1'b1;
      rd_enb = 1'b0;
      wait_init("init2");
      cycle(1'b0, '0, '0, 1'b1, 12'h100);
      chk("reinit_valid", DW'(rd_valid), 1);
      chk("reinit_addr100", rd_data, '0);
      cycle(1'b0, '0, '0, 1'b1, 12'h005);
      chk("reinit_addr005", rd_data, '0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ram_dp_mem.md
# ram_dp_mem

Synchronous dual-port RAM that the write and read agents drive: one write port and one independent read port, with a registered read and a `rd_valid` qualifier. After reset the memory zero-fills itself, one word per cycle, before accepting traffic. Both ports report `ready` so the drivers can hold requests off during initialisation. Same-cycle write/read collisions to one address are resolved write-first.

## Interface
- `DATA_WIDTH`, 64, width of each word and of both data buses.
- `ADDR_WIDTH`, 12, address width; depth is 2**ADDR_WIDTH words (4096 at default).

- `clk`, in, 1, single clock; all state updates on rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `wr_enb`, in, 1, write request.
- `wr_addr`, in, ADDR_WIDTH, write address.
- `wr_data`, in, DATA_WIDTH, write data.
- `wr_ready`, out, 1, write port accepting; a write is performed only when `wr_enb && wr_ready`.
- `rd_enb`, in, 1, read request.
- `rd_addr`, in, ADDR_WIDTH, read address.
- `rd_ready`, out, 1, read port accepting; a read is performed only when `rd_enb && rd_ready`.
- `rd_data`, out, DATA_WIDTH, registered read data.
- `rd_valid`, out, 1, one-cycle pulse qualifying `rd_data`.
- `init_busy`, out, 1, high while zero-fill is in progress.

## Operation
- FSM has two states, INIT and RUN.
- Reset entry:
  - `rst_n` low (async) forces state INIT and `init_cnt`=0.
  - Outputs during reset: `rd_data`=0, `rd_valid`=0, `init_busy`=1, `wr_ready`=0, `rd_ready`=0.
- INIT state:
  - Each cycle writes 0 to `mem[init_cnt]` and increments `init_cnt`.
  - When `init_cnt` == 2**ADDR_WIDTH-1 and that word is written, the next state is RUN.
  - `init_cnt` is ADDR_WIDTH bits wide and must not wrap into a second pass.
  - `wr_enb` and `rd_enb` are ignored: no memory change and no `rd_valid`.
- RUN state:
  - `init_busy`=0 and `wr_ready`=`rd_ready`=1.
  - The block stays in RUN until reset.
- Accepted write: `mem[wr_addr]` <= `wr_data` at the edge.
- Accepted read: at the edge, `rd_data` <= `mem[rd_addr]` and `rd_valid` <= 1.
- Cycle with no accepted read: `rd_valid` <= 0 and `rd_data` holds its last value.
- Collision: an accepted read and an accepted write in the same cycle with `rd_addr` == `wr_addr` return `wr_data` (write-first bypass).
- A read and a write to different addresses in the same cycle are fully independent.
- Back-to-back reads are allowed every cycle; `rd_valid` then stays high continuously.
- Reset mid-operation:
  - Asynchronous clear of `rd_valid`/`rd_data` and return to INIT.
  - Memory is fully re-zeroed, so no prior contents survive a reset.
- No X-propagation from unwritten words, because INIT fills every location.

## Timing
- Reset release: `init_busy` stays high for exactly 2**ADDR_WIDTH cycles after the first rising edge with `rst_n` high.
- `wr_ready`/`rd_ready` rise on the cycle that `init_busy` falls.
- Write latency: the data is visible to a read issued the cycle after the write edge. It is visible in the same cycle only via the collision bypass.
- Read latency: 1 cycle from accept edge to `rd_data`/`rd_valid` valid. Both are registered outputs with no combinational path from inputs.
- `ready` signals depend only on FSM state, never on `wr_enb`/`rd_enb`.

## Test plan
- Reset/init:
  - Stimulus: assert `rst_n`=0 for 3 cycles, release, count cycles.
  - Required response: `init_busy`=1 for exactly 4096 cycles, then `wr_ready`=`rd_ready`=1.
  - Required response: a read of every address returns 0 with one `rd_valid` per read.
- Write then read:
  - Stimulus: write 0xDEAD_BEEF_0000_0001 at addr 0x005, then read addr 0x005 the next cycle.
  - Required response: `rd_data`=0xDEAD_BEEF_0000_0001, `rd_valid` high exactly 1 cycle after the read accept.
- Collision:
  - Stimulus: same cycle, write 0x1234 to addr 0xFFF and read addr 0xFFF, where old content is 0x0.
  - Required response: `rd_data`=0x1234.
  - Stimulus: same cycle, write to 0x010 and read 0x011.
  - Required response: the read returns the old content of 0x011.
- Ignored during INIT:
  - Stimulus: drive `wr_enb`=1 (addr 0x7, data 0xAA) and `rd_enb`=1 during INIT.
  - Required response: no `rd_valid`; after init, a read of 0x7 returns 0.
- Streaming and boundaries:
  - Stimulus: write addresses 0x000 and 0xFFF; issue 8 consecutive reads alternating them.
  - Required response: `rd_valid` high for 8 consecutive cycles with correct data; `rd_data` holds after the last read.
- Mid-run reset:
  - Stimulus: write 0x55 to addr 0x100, pulse `rst_n` low for 1 cycle mid-read.
  - Required response: `rd_valid`/`rd_data` clear immediately, `init_busy` reasserts, and after re-init a read of 0x100 returns 0.
